// File: rtl/gcd_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_rr_scheduler
//  Purpose  : Round-robin arbiter sharing one subtractive GCD engine among
//             NREQ requesters; reports result, step count and requester id.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    done_valid,
  output logic [IDW-1:0]          done_id,
  output logic [WIDTH-1:0]        result,
  output logic [WIDTH-1:0]        steps
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH-1:0]  r_cnt;
  logic [IDW-1:0]    r_last_id;
  logic [NREQ-1:0]   r_grant;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  r_steps;
  logic [IDW-1:0]    r_done_id;

  logic              w_found;
  logic [IDW-1:0]    w_winner;
  logic [WIDTH-1:0]  w_win_a;
  logic [WIDTH-1:0]  w_win_b;
  logic [NREQ-1:0]   w_grant_oh;
  logic              w_finish;

  // Search starts one past the last winner so every held request is reached
  // within NREQ acceptances.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_win_a  = '0;
    w_win_b  = '0;
    v_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = IDW'((int'(r_last_id) + k) % NREQ);
      if (!w_found && req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
        w_win_a  = a_in[v_idx*WIDTH +: WIDTH];
        w_win_b  = b_in[v_idx*WIDTH +: WIDTH];
      end
    end
  end

  assign w_grant_oh = NREQ'(1) << w_winner;
  assign w_finish   = (r_opa == '0) || (r_opb == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_finish) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The working step counter restarts per job; the visible steps/result/id
  // registers only change on entry to DONE so they hold between jobs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_last_id <= IDW'(NREQ - 1);
      r_grant   <= '0;
      r_result  <= '0;
      r_steps   <= '0;
      r_done_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_opa     <= w_win_a;
            r_opb     <= w_win_b;
            r_cnt     <= '0;
            r_grant   <= w_grant_oh;
            r_last_id <= w_winner;
          end
        end
        ST_RUN: begin
          if (r_opa == '0) begin
            r_result  <= r_opb;
            r_steps   <= r_cnt;
            r_done_id <= r_last_id;
          end else if (r_opb == '0) begin
            r_result  <= r_opa;
            r_steps   <= r_cnt;
            r_done_id <= r_last_id;
          end else if (r_opa > r_opb) begin
            r_opa <= r_opa - r_opb;
            r_cnt <= r_cnt + WIDTH'(1);
          end else begin
            r_opb <= r_opb - r_opa;
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_grant <= '0;
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign done_valid = (r_state == ST_DONE);
  assign done_id    = r_done_id;
  assign result     = r_result;
  assign steps      = r_steps;

endmodule
`default_nettype wire
